permutation_sequencer: RTL and testbench

Control FSM for the iterative single-round ASCON permutation datapath (constant addition, substitution, diffusion, state register). It sequences one permutation of 12, 8 or 6 rounds per request: it drives the round index, the input-select mux and the state-register enable, and signals when the result is valid. It sits between the ASCON mode FSM, which requests pa/pb permutations, and the round datapath.

---
 rtl/permutation_sequencer_pkg.sv | 42 ++++
 rtl/permutation_sequencer.sv | 107 ++++++++++
 tb/tb_permutation_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/permutation_sequencer_pkg.sv
// Shared ASCON definitions used by the permutation control logic:
// the sequencer state encoding, the round-select encoding, the round-count constants,
// and a helper that maps a round selection to its starting round index.
package permutation_sequencer_pkg;

   // ASCON round counts. pa is the initialisation/finalisation permutation, and pb is the
   // data-processing permutation. The 8-round variant is used by ASCON-128a.
   localparam int ROUNDS_A = 12;
   localparam int ROUNDS_8 = 8;
   localparam int ROUNDS_B = 6;

   // Index of the final round. Every permutation ends on this index, whatever its length.
   localparam logic [3:0] LAST_ROUND = 4'd11;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } seq_state_t;

   // Round-count selection, as presented by the mode FSM.
   typedef enum logic [1:0] {
      SEL_P12     = 2'b00,
      SEL_P8      = 2'b01,
      SEL_P6      = 2'b10,
      SEL_P12_ALT = 2'b11
   } rounds_sel_t;

   // Returns the first round index of a permutation, which is 12 - N.
   // The counter then runs up to LAST_ROUND, so the final round is always index 11.
   function automatic logic [3:0] first_round(input rounds_sel_t sel);
      logic [3:0] r;
      case (sel)
         SEL_P8:  r = 4'(ROUNDS_A - ROUNDS_8);
         SEL_P6:  r = 4'(ROUNDS_A - ROUNDS_B);
         default: r = 4'd0;   // SEL_P12 and SEL_P12_ALT both select the full pa
      endcase
      return r;
   endfunction

endpackage

// File: rtl/permutation_sequencer.sv
// Control FSM for the iterative single-round ASCON permutation datapath.
// Latency: a request accepted at edge k runs rounds in cycles k+1..k+N, pulses done_o in
//   cycle k+N+1, and is ready again in cycle k+N+2.
// Backpressure: start_i is accepted only while ready_o=1. Requests made at any other time
//   are dropped, not queued.
// Ports:
//   clock_i, reset_i  rising-edge clock, synchronous active-high reset
//   start_i           permutation request
//   rounds_sel_i      round count, sampled at accept (00/11 = 12, 01 = 8, 10 = 6)
//   ready_o           idle, can accept a request
//   round_o           round index for the constant-add stage
//   input_mode_o      datapath mux: 0 = external state, 1 = loop-back register
//   enable_o          state-register enable
//   busy_o            rounds executing
//   done_o            one-cycle pulse when the register holds the permuted state
module permutation_sequencer
   import permutation_sequencer_pkg::*;
(
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [1:0] rounds_sel_i,
   output logic       ready_o,
   output logic [3:0] round_o,
   output logic       input_mode_o,
   output logic       enable_o,
   output logic       busy_o,
   output logic       done_o
);

   seq_state_t state, state_nxt;
   logic [3:0] round_cnt, round_cnt_nxt;
   logic       first, first_nxt;

   // State register, round counter and first-cycle flag.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state     <= ST_IDLE;
         round_cnt <= 4'd0;
         first     <= 1'b0;
      end else begin
         state     <= state_nxt;
         round_cnt <= round_cnt_nxt;
         first     <= first_nxt;
      end
   end

   // Next-state logic. rounds_sel_i is looked at only on an accepted request, so changes
   // while a permutation runs have no effect.
   always_comb begin
      state_nxt     = state;
      round_cnt_nxt = round_cnt;
      first_nxt     = first;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               state_nxt     = ST_RUN;
               round_cnt_nxt = first_round(rounds_sel_t'(rounds_sel_i));
               first_nxt     = 1'b1;
            end
         end
         ST_RUN: begin
            first_nxt = 1'b0;
            if (round_cnt == LAST_ROUND) begin
               // Hold the counter at 11 so that it never wraps.
               state_nxt = ST_DONE;
            end else begin
               round_cnt_nxt = round_cnt + 4'd1;
            end
         end
         ST_DONE: begin
            state_nxt     = ST_IDLE;
            round_cnt_nxt = 4'd0;
         end
         default: begin
            state_nxt     = ST_IDLE;
            round_cnt_nxt = 4'd0;
            first_nxt     = 1'b0;
         end
      endcase
   end

   // Outputs depend only on registered state, so there is no path from start_i to any output.
   // round_o and input_mode_o are forced to 0 outside RUN.
   always_comb begin
      ready_o      = 1'b0;
      round_o      = 4'd0;
      input_mode_o = 1'b0;
      enable_o     = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      case (state)
         ST_IDLE: ready_o = 1'b1;
         ST_RUN: begin
            enable_o     = 1'b1;
            busy_o       = 1'b1;
            round_o      = round_cnt;
            // The external state enters on the first round only; after that the loop-back
            // register feeds the datapath.
            input_mode_o = ~first;
         end
         ST_DONE: done_o = 1'b1;
         default: ready_o = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_permutation_sequencer.sv
module tb_permutation_sequencer;

   logic       clock;
   logic       reset;
   logic       start;
   logic [1:0] rounds_sel;
   logic       ready;
   logic [3:0] round;
   logic       input_mode;
   logic       enable;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   // Reference model: whether a permutation is outstanding, the number of cycles since its
   // accept, and its round count.
   bit m_active = 0;
   int m_t      = 0;
   int m_n      = 0;
   int m_done_cnt   = 0;
   int dut_done_cnt = 0;

   permutation_sequencer dut (
      .clock_i      (clock),
      .reset_i      (reset),
      .start_i      (start),
      .rounds_sel_i (rounds_sel),
      .ready_o      (ready),
      .round_o      (round),
      .input_mode_o (input_mode),
      .enable_o     (enable),
      .busy_o       (busy),
      .done_o       (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int n_of(input logic [1:0] sel);
      case (sel)
         2'b01:   return 8;
         2'b10:   return 6;
         default: return 12;
      endcase
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives the inputs for one cycle, advances the model across the rising edge, and then
   // checks every output on the following falling edge.
   task automatic step(input logic s, input logic [1:0] sel, input logic r);
      logic       e_ready, e_mode, e_en, e_busy, e_done;
      logic [3:0] e_round;
      start = s;
      rounds_sel = sel;
      reset = r;
      @(posedge clock);
      if (r) begin
         m_active = 0;
      end else if (!m_active) begin
         if (s) begin
            m_active = 1;
            m_t = 1;
            m_n = n_of(sel);
         end
      end else begin
         m_t++;
         if (m_t == m_n + 2) m_active = 0;
      end
      e_ready = 0; e_mode = 0; e_en = 0; e_busy = 0; e_done = 0; e_round = 0;
      if (!m_active) begin
         e_ready = 1;
      end else if (m_t <= m_n) begin
         e_en    = 1;
         e_busy  = 1;
         e_round = 4'(12 - m_n + m_t - 1);
         e_mode  = (m_t > 1);
      end else begin
         e_done = 1;
      end
      @(negedge clock);
      check("ready",      {3'b0, ready},      {3'b0, e_ready});
      check("round",      round,              e_round);
      check("input_mode", {3'b0, input_mode}, {3'b0, e_mode});
      check("enable",     {3'b0, enable},     {3'b0, e_en});
      check("busy",       {3'b0, busy},       {3'b0, e_busy});
      check("done",       {3'b0, done},       {3'b0, e_done});
      if (e_done) m_done_cnt++;
      if (done)   dut_done_cnt++;
   endtask

   initial begin
      start = 0;
      rounds_sel = 0;
      reset = 1;
      @(negedge clock);

      // Reset values
      step(0, 2'b00, 1);
      step(1, 2'b00, 1);   // reset wins over start
      step(0, 2'b00, 0);

      // p12, p6, p8, and sel=11 treated as p12
      step(1, 2'b00, 0);
      repeat (15) step(0, 2'b00, 0);
      step(1, 2'b10, 0);
      repeat (9) step(0, 2'b10, 0);
      step(1, 2'b01, 0);
      repeat (11) step(0, 2'b01, 0);
      step(1, 2'b11, 0);
      repeat (15) step(0, 2'b11, 0);

      // start held high with p6: one accept every 8 cycles, and no restart in RUN/DONE
      repeat (34) step(1, 2'b10, 0);
      repeat (3) step(0, 2'b10, 0);

      // Reset during the 5th RUN cycle of p12, then a full p12
      step(1, 2'b00, 0);
      repeat (4) step(0, 2'b00, 0);
      step(1, 2'b00, 1);
      step(0, 2'b00, 0);
      step(1, 2'b00, 0);
      repeat (15) step(0, 2'b00, 0);

      // rounds_sel toggles while running
      step(1, 2'b10, 0);
      repeat (10) step(0, 2'($urandom_range(0, 3)), 0);
      step(1, 2'b00, 0);
      repeat (15) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0);

      // Random traffic with occasional resets
      repeat (400) begin
         step(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 60) == 0));
      end
      repeat (16) step(0, 2'b00, 0);

      total++;
      assert (dut_done_cnt === m_done_cnt) else begin
         bad++;
         $error("FAIL done_count: observed=%0d expected=%0d", dut_done_cnt, m_done_cnt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
